// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer for the ProgramCounter, with a small CALL/RET return-address stack.
// Latency: control is issued the cycle after the handshake. InstrReady is high only in FETCH.
// Backpressure: InstrValid is ignored outside FETCH.
module pc_sequencer #(
    parameter int PC_WIDTH     = 16,
    parameter int OFFSET_WIDTH = 9,
    parameter int STACK_DEPTH  = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [PC_WIDTH-1:0]     CounterValue,
    input  logic                    InstrValid,
    output logic                    InstrReady,
    input  logic [2:0]              Opcode,
    input  logic [PC_WIDTH-1:0]     Target,
    input  logic [OFFSET_WIDTH-1:0] BranchOffset,
    input  logic                    ZeroFlag,
    input  logic                    Resume,
    output logic [PC_WIDTH-1:0]     PCLoadValue,
    output logic                    PCLoadEnable,
    output logic [OFFSET_WIDTH-1:0] PCOffset,
    output logic                    PCOffsetEnable,
    output logic                    Halted,
    output logic                    StackFault
);
    localparam int SPW = $clog2(STACK_DEPTH);
    localparam logic [SPW:0] SP_FULL = (SPW+1)'(STACK_DEPTH);
    localparam logic [SPW:0] SP_ONE  = (SPW+1)'(1);
    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_BR   = 3'd2;
    localparam logic [2:0] OP_BRZ  = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;

    typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_HALT} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              opc_q, opc_d;
    logic [PC_WIDTH-1:0]     tgt_q, tgt_d;
    logic [OFFSET_WIDTH-1:0] off_q, off_d;
    logic [SPW:0]            sp_q, sp_d;
    logic                    fault_q, fault_d;
    logic [PC_WIDTH-1:0]     stack_q [STACK_DEPTH];
    logic [PC_WIDTH-1:0]     stack_d [STACK_DEPTH];

    logic                    ready;
    logic                    load_en;
    logic [PC_WIDTH-1:0]     load_val;
    logic                    off_en;
    logic [OFFSET_WIDTH-1:0] off_val;
    logic [SPW:0]            sp_dec;

    assign sp_dec = sp_q - SP_ONE;

    always_comb begin
        state_d  = state_q;
        opc_d    = opc_q;
        tgt_d    = tgt_q;
        off_d    = off_q;
        sp_d     = sp_q;
        fault_d  = fault_q;
        stack_d  = stack_q;
        ready    = 1'b0;
        load_en  = 1'b0;
        load_val = '0;
        off_en   = 1'b1;
        off_val  = '0;
        case (state_q)
            ST_FETCH: begin
                ready = 1'b1;
                if (InstrValid) begin
                    opc_d   = Opcode;
                    tgt_d   = Target;
                    off_d   = BranchOffset;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                off_en  = 1'b0;
                case (opc_q)
                    OP_JMP: begin
                        load_en  = 1'b1;
                        load_val = tgt_q;
                    end
                    OP_BR: begin
                        off_en  = 1'b1;
                        off_val = off_q;
                    end
                    OP_BRZ: begin
                        if (ZeroFlag) begin
                            off_en  = 1'b1;
                            off_val = off_q;
                        end
                    end
                    OP_CALL: begin
                        if (sp_q == SP_FULL) begin
                            off_en  = 1'b1;
                            fault_d = 1'b1;
                            state_d = ST_HALT;
                        end else begin
                            stack_d[sp_q[SPW-1:0]] = CounterValue + PC_ONE;
                            sp_d     = sp_q + SP_ONE;
                            load_en  = 1'b1;
                            load_val = tgt_q;
                        end
                    end
                    OP_RET: begin
                        if (sp_q == '0) begin
                            off_en  = 1'b1;
                            fault_d = 1'b1;
                            state_d = ST_HALT;
                        end else begin
                            sp_d     = sp_dec;
                            load_en  = 1'b1;
                            load_val = stack_q[sp_dec[SPW-1:0]];
                        end
                    end
                    OP_HALT: begin
                        off_en  = 1'b1;
                        state_d = ST_HALT;
                    end
                    default: ;
                endcase
            end
            ST_HALT: begin
                if (Resume) begin
                    off_en  = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_FETCH;
            opc_q   <= OP_NOP;
            tgt_q   <= '0;
            off_q   <= '0;
            sp_q    <= '0;
            fault_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            tgt_q   <= tgt_d;
            off_q   <= off_d;
            sp_q    <= sp_d;
            fault_q <= fault_d;
            stack_q <= stack_d;
        end
    end

    // Reset forces a PC hold on the outputs regardless of the registered state.
    assign InstrReady     = Reset & ready;
    assign PCLoadEnable   = Reset & load_en;
    assign PCLoadValue    = Reset ? load_val : '0;
    assign PCOffsetEnable = ~Reset | off_en;
    assign PCOffset       = Reset ? off_val : '0;
    assign Halted         = Reset & (state_q == ST_HALT);
    assign StackFault     = fault_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a ProgramCounter stand-in plus an instruction-level reference model
// (expected PC per instruction, return addresses in a queue), directed cases then random ones.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc;
    logic        InstrValid = 1'b0;
    logic        InstrReady;
    logic [2:0]  Opcode = 3'd0;
    logic [15:0] Target = 16'd0;
    logic [8:0]  BranchOffset = 9'd0;
    logic        ZeroFlag = 1'b0;
    logic        Resume = 1'b0;
    logic [15:0] PCLoadValue;
    logic        PCLoadEnable;
    logic [8:0]  PCOffset;
    logic        PCOffsetEnable;
    logic        Halted;
    logic        StackFault;

    int total = 0;
    int bad   = 0;

    logic [15:0] mpc = 16'd0;
    logic [15:0] ra[$];
    bit          mfault = 1'b0;
    bit          mhalt  = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .Clock(clk), .Reset(rst_n), .CounterValue(pc),
        .InstrValid(InstrValid), .InstrReady(InstrReady),
        .Opcode(Opcode), .Target(Target), .BranchOffset(BranchOffset),
        .ZeroFlag(ZeroFlag), .Resume(Resume),
        .PCLoadValue(PCLoadValue), .PCLoadEnable(PCLoadEnable),
        .PCOffset(PCOffset), .PCOffsetEnable(PCOffsetEnable),
        .Halted(Halted), .StackFault(StackFault)
    );

    // ProgramCounter stand-in, same contract as the real block
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)              pc <= 16'd0;
        else if (PCLoadEnable)   pc <= PCLoadValue;
        else if (PCOffsetEnable) pc <= pc + {{7{PCOffset[8]}}, PCOffset};
        else                     pc <= pc + 16'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_forced(input string tag);
        chk({tag, "_ready"},   InstrReady, 0);
        chk({tag, "_load_en"}, PCLoadEnable, 0);
        chk({tag, "_load_val"}, PCLoadValue, 0);
        chk({tag, "_off_en"},  PCOffsetEnable, 1);
        chk({tag, "_off"},     PCOffset, 0);
        chk({tag, "_halted"},  Halted, 0);
        chk({tag, "_fault"},   StackFault, 0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0; InstrValid = 1'b0; Resume = 1'b0;
        #1;
        chk_forced("rst");
        mpc = 16'd0; ra.delete(); mfault = 1'b0; mhalt = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", InstrReady, 1);
        chk("rst_release_pc", pc, 16'd0);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        InstrValid = 1'b0; ZeroFlag = 1'($urandom);
        #1;
        chk("idle_ready", InstrReady, 1);
        chk("idle_hold_en", PCOffsetEnable, 1);
        chk("idle_hold_off", PCOffset, 0);
        chk("idle_load_en", PCLoadEnable, 0);
        @(posedge clk); #1;
        chk("idle_pc", pc, mpc);
    endtask

    task automatic exec_instr(input logic [2:0] op, input logic [15:0] tgt,
                              input logic [8:0] off, input logic zf);
        logic [15:0] pc0, npc, lv;
        logic        le, oe;
        logic [8:0]  ov;
        @(negedge clk);
        #1;
        chk("fetch_ready", InstrReady, 1);
        chk("fetch_hold_en", PCOffsetEnable, 1);
        chk("fetch_hold_off", PCOffset, 0);
        chk("fetch_load_en", PCLoadEnable, 0);
        chk("fetch_halted", Halted, 0);
        chk("fetch_pc", pc, mpc);
        InstrValid = 1'b1; Opcode = op; Target = tgt; BranchOffset = off;
        @(posedge clk);
        @(negedge clk);
        // Garbage on the instruction bus must not matter once the fields are captured
        InstrValid = 1'($urandom); Opcode = 3'($urandom); Target = 16'($urandom);
        BranchOffset = 9'($urandom); Resume = 1'($urandom); ZeroFlag = zf;
        #1;
        pc0 = mpc; npc = pc0 + 16'd1; le = 1'b0; oe = 1'b0; lv = 16'd0; ov = 9'd0;
        case (op)
            3'd1: begin le = 1'b1; lv = tgt; npc = tgt; end
            3'd2: begin oe = 1'b1; ov = off; npc = 16'(int'(pc0) + int'($signed(off))); end
            3'd3: if (zf) begin oe = 1'b1; ov = off; npc = 16'(int'(pc0) + int'($signed(off))); end
            3'd4: begin
                if (ra.size() == 4) begin
                    oe = 1'b1; npc = pc0; mfault = 1'b1; mhalt = 1'b1;
                end else begin
                    ra.push_back(pc0 + 16'd1); le = 1'b1; lv = tgt; npc = tgt;
                end
            end
            3'd5: begin
                if (ra.size() == 0) begin
                    oe = 1'b1; npc = pc0; mfault = 1'b1; mhalt = 1'b1;
                end else begin
                    lv = ra.pop_back(); le = 1'b1; npc = lv;
                end
            end
            3'd6: begin oe = 1'b1; npc = pc0; mhalt = 1'b1; end
            default: ;
        endcase
        chk("exec_ready", InstrReady, 0);
        chk("exec_halted", Halted, 0);
        chk("exec_load_en", PCLoadEnable, le);
        if (le) chk("exec_load_val", PCLoadValue, lv);
        chk("exec_off_en", PCOffsetEnable, oe);
        if (oe) chk("exec_off", PCOffset, ov);
        @(posedge clk); #1;
        InstrValid = 1'b0; Resume = 1'b0;
        mpc = npc;
        chk("pc_after", pc, mpc);
        chk("halted_after", Halted, mhalt);
        chk("fault_after", StackFault, mfault);
    endtask

    task automatic do_resume();
        @(negedge clk);
        InstrValid = 1'b1; Opcode = 3'd1; Target = 16'($urandom); Resume = 1'b0;
        #1;
        chk("halt_flag", Halted, 1);
        chk("halt_ready", InstrReady, 0);
        chk("halt_hold_en", PCOffsetEnable, 1);
        chk("halt_hold_off", PCOffset, 0);
        chk("halt_load_en", PCLoadEnable, 0);
        @(posedge clk); #1;
        chk("halt_pc_held", pc, mpc);
        chk("halt_ignores_valid", Halted, 1);
        @(negedge clk);
        InstrValid = 1'b0; Resume = 1'b1;
        #1;
        chk("resume_off_en", PCOffsetEnable, 0);
        chk("resume_load_en", PCLoadEnable, 0);
        @(posedge clk); #1;
        Resume = 1'b0;
        mpc = mpc + 16'd1; mhalt = 1'b0;
        chk("resume_pc", pc, mpc);
        chk("resume_halted", Halted, 0);
        chk("resume_ready", InstrReady, 1);
        chk("resume_fault", StackFault, mfault);
    endtask

    initial begin
        // Reset state while held in reset
        #2;
        chk_forced("por");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("por_release_ready", InstrReady, 1);

        // NOP then JMP
        exec_instr(3'd0, 16'h0000, 9'd0, 1'b0);
        chk("nop_pc_one", pc, 16'h0001);
        exec_instr(3'd1, 16'h1234, 9'd0, 1'b0);
        chk("jmp_pc", pc, 16'h1234);
        idle_cycle();

        // Branches from 0x0100
        exec_instr(3'd1, 16'h0100, 9'd0, 1'b0);
        exec_instr(3'd2, 16'h0000, 9'h1FC, 1'b0);
        chk("br_neg4", pc, 16'h00FC);
        exec_instr(3'd3, 16'h0000, 9'd8, 1'b0);
        chk("brz_not_taken", pc, 16'h00FD);
        exec_instr(3'd3, 16'h0000, 9'd8, 1'b1);
        chk("brz_taken", pc, 16'h0105);
        exec_instr(3'd7, 16'hFFFF, 9'h1FF, 1'b1);
        chk("op7_nop", pc, 16'h0106);

        // CALL/RET
        exec_instr(3'd1, 16'h0010, 9'd0, 1'b0);
        exec_instr(3'd4, 16'h2000, 9'd0, 1'b0);
        chk("call_pc", pc, 16'h2000);
        exec_instr(3'd5, 16'h0000, 9'd0, 1'b0);
        chk("ret_pc", pc, 16'h0011);

        // Nested: 4 fit, 5th faults; fault survives Resume
        for (int i = 0; i < 4; i++) exec_instr(3'd4, 16'h3000 + 16'(i * 16), 9'd0, 1'b0);
        exec_instr(3'd4, 16'h4000, 9'd0, 1'b0);
        chk("call5_fault", StackFault, 1);
        chk("call5_halted", Halted, 1);
        chk("call5_pc_held", pc, 16'h3030);
        do_resume();
        chk("fault_sticky", StackFault, 1);
        for (int i = 0; i < 4; i++) exec_instr(3'd5, 16'h0000, 9'd0, 1'b0);

        // Return-address wrap at the top of the PC space
        exec_instr(3'd1, 16'hFFFF, 9'd0, 1'b0);
        exec_instr(3'd4, 16'h5000, 9'd0, 1'b0);
        exec_instr(3'd5, 16'h0000, 9'd0, 1'b0);
        chk("ret_wrap", pc, 16'h0000);

        // HALT, then reset while halted; stack must come back empty
        exec_instr(3'd4, 16'h0700, 9'd0, 1'b0);
        exec_instr(3'd6, 16'h0000, 9'd0, 1'b0);
        chk("halt_state", Halted, 1);
        reset_pulse();
        exec_instr(3'd5, 16'h0000, 9'd0, 1'b0);
        chk("ret_after_reset_faults", StackFault, 1);
        do_resume();

        // Reset during EXECUTE drops the pending JMP
        @(negedge clk);
        InstrValid = 1'b1; Opcode = 3'd1; Target = 16'h5555;
        @(posedge clk);
        reset_pulse();
        idle_cycle();
        chk("exec_reset_dropped", pc, 16'h0000);

        // Random instruction stream
        for (int n = 0; n < 400; n++) begin
            if (mhalt) do_resume();
            else if ($urandom_range(0, 5) == 0) idle_cycle();
            else exec_instr(3'($urandom), 16'($urandom), 9'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
